result_collector: RTL
=====================

# result_collector

Output-side companion to the matrix loader: captures each complex accumulator result (accR/accI) as the multiply datapath flags it, buffers the full DIM×DIM product matrix row-major, then drains it over a valid/ready stream tagged with row/column indices. Sits between the accumulators (flagR/flagI, accR/accI) and the host or testbench readback path, replacing file-dump-on-flag with a synthesizable unloader.

## Interface
- ANCHOPALABRA, 32, word width of accR/accI and out_real/out_imag (signed, Q[20:-11] at 32)
- DIM, 3, matrix dimension; legal range ≥2
- clk_fast  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- flagR  in  1  real-accumulator done flag; rising edge marks accR valid
- flagI  in  1  imag-accumulator done flag; rising edge marks accI valid
- accR  in  ANCHOPALABRA  real accumulator value
- accI  in  ANCHOPALABRA  imaginary accumulator value
- clr  in  1  synchronous restart: DONE→COLLECT, clears indices and errors
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts
- out_real  out  ANCHOPALABRA  buffered real part
- out_imag  out  ANCHOPALABRA  buffered imaginary part
- out_row  out  $clog2(DIM)  row of current word
- out_col  out  $clog2(DIM)  column of current word
- out_last  out  1  high with element DIM*DIM-1
- done  out  1  matrix fully drained
- err_pair  out  1  sticky: second edge on one flag before its partner arrived
- err_ovf  out  1  sticky: flag edge outside COLLECT
- checksum  out  ANCHOPALABRA  only with RESCOL_CHECKSUM_EN

## Operation
- Edge detect: flagX_q registered each cycle; capture when flagX & ~flagX_q, sampling accX on that same clock edge.
- Pairing: captured real/imag held in pend_r/pend_i with pend flags. Entry written to buf[wr_idx] on the cycle both pend flags are set (or both edges arrive in the same cycle; pair written that cycle). Pend flags cleared on write.
- Repeated edge on a flag whose pend is already set: new value overwrites, err_pair←1.
- States: COLLECT (reset state), DRAIN, DONE.
- COLLECT: wr_idx 0..DIM*DIM-1; write at DIM*DIM-1 → DRAIN next cycle, wr_idx←0.
- DRAIN: out_valid=1; out_* = buf[rd_idx], row/col from counters (col wraps at DIM-1, row increments). Transfer on out_valid&out_ready; rd_idx++. Transfer with out_last → DONE.
- DONE: done=1, out_valid=0; holds until clr. clr in DONE → COLLECT; clr in other states ignored except clearing err_pair/err_ovf.
- Flag edges in DRAIN/DONE: data dropped, err_ovf←1.

## Timing
- Reset (async): state=COLLECT, all indices/pend/q regs 0, out_valid=0, out_real/out_imag=0, out_row/out_col=0, out_last=0, done=0, err_pair=0, err_ovf=0, checksum=0. Buffer contents not reset.
- Capture latency: edge-detect cycle is capture cycle; pair write same edge.
- out_valid first high 1 cycle after final pair write.
- Stream: out_* stable while out_valid&~out_ready; max throughput 1 word/cycle; DIM*DIM cycles minimum drain.
- done high the cycle after last transfer.
- Reset mid-DRAIN aborts stream immediately; no partial last.

## Configuration
- RESCOL_CHECKSUM_EN defined: checksum port present = XOR of every real and imag word written in the current matrix, updated on each pair write, cleared by clr/rst; valid when state leaves COLLECT.
- Undefined: no checksum port, no XOR logic.

## Test plan
- DIM=3, nine paired pulses with accR=k, accI=-k (k=0..8), out_ready=1 → nine words row-major, (row,col) (0,0)…(2,2), out_last only on k=8, done next cycle.
- flagR pulses, flagI 5 cycles later, accR/accI changing between → stored pair equals values at each respective edge; err_pair=0.
- Two flagR edges (accR=1 then 2) before flagI → err_pair=1, stored real=2.
- Drain with out_ready toggling 1-0-0-1 → each word held stable while stalled, no word lost or duplicated.
- Flag edge during DRAIN → err_ovf=1, stream unaffected; clr in DONE → COLLECT, second matrix collects from index 0.
- With RESCOL_CHECKSUM_EN, real={1,2,…,9}, imag=0 → checksum=32'h1 (1^2^…^9).

Source files
------------

// File: rtl/result_collector_if.sv
// result_collector_if
//   Output stream of the result collector: one complex matrix element per
//   transfer, tagged with its row/column position.
//
//   Parameters
//     ANCHOPALABRA  word width of out_real/out_imag
//     DIM           matrix dimension (row/column tags are $clog2(DIM) wide)
//
//   Signals
//     out_valid  collector -> sink  word on the bus is valid
//     out_ready  sink -> collector  sink accepts the current word
//     out_real   collector -> sink  real part of the element
//     out_imag   collector -> sink  imaginary part of the element
//     out_row    collector -> sink  row index of the element
//     out_col    collector -> sink  column index of the element
//     out_last   collector -> sink  final element of the matrix
//
//   Modports: master (the collector), slave (the consumer).
interface result_collector_if #(
  parameter int ANCHOPALABRA = 32,
  parameter int DIM          = 3
);
  localparam int RC_W = $clog2(DIM);

  logic                    out_valid;
  logic                    out_ready;
  logic [ANCHOPALABRA-1:0] out_real;
  logic [ANCHOPALABRA-1:0] out_imag;
  logic [RC_W-1:0]         out_row;
  logic [RC_W-1:0]         out_col;
  logic                    out_last;

  modport master (
    output out_valid, out_real, out_imag, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_real, out_imag, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_collector.sv
// result_collector
//   Captures complex accumulator results on the rising edges of their done
//   flags, pairs real and imaginary halves, buffers a full DIM x DIM matrix
//   row-major, then drains it over a valid/ready stream with row/column tags.
//
//   Parameters
//     ANCHOPALABRA  data word width (signed fixed point)
//     DIM           matrix dimension, >= 2
//
//   Ports
//     clk_fast   single clock, everything on posedge
//     rst        asynchronous active-high reset
//     flagR      real accumulator done flag (rising edge = accR valid)
//     flagI      imag accumulator done flag (rising edge = accI valid)
//     accR/accI  accumulator values
//     clr        restart from DONE; in any state clears the error flags
//     stream     result_collector_if.master output stream
//     done       matrix fully drained
//     err_pair   sticky: repeated edge on a flag before its partner arrived
//     err_ovf    sticky: flag edge while not collecting (data dropped)
//     checksum   XOR of all words written this matrix
//                (present only when RESCOL_CHECKSUM_EN is defined)
//
//   Optional feature macro: RESCOL_CHECKSUM_EN
module result_collector #(
  parameter int ANCHOPALABRA = 32,
  parameter int DIM          = 3
) (
  input  logic                    clk_fast,
  input  logic                    rst,
  input  logic                    flagR,
  input  logic                    flagI,
  input  logic [ANCHOPALABRA-1:0] accR,
  input  logic [ANCHOPALABRA-1:0] accI,
  input  logic                    clr,
  result_collector_if.master      stream,
  output logic                    done,
  output logic                    err_pair,
  output logic                    err_ovf
`ifdef RESCOL_CHECKSUM_EN
  ,
  output logic [ANCHOPALABRA-1:0] checksum
`endif
);

  localparam int NUM   = DIM * DIM;
  localparam int IDX_W = $clog2(NUM);
  localparam int RC_W  = $clog2(DIM);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                    flagR_q, flagI_q;
  logic [ANCHOPALABRA-1:0] pend_r, pend_i;
  logic                    pend_r_v, pend_i_v;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [RC_W-1:0]         row_cnt, col_cnt;

  logic [ANCHOPALABRA-1:0] mem_r [NUM];
  logic [ANCHOPALABRA-1:0] mem_i [NUM];

  logic                    edge_r, edge_i;
  logic                    in_collect, in_drain;
  logic                    pair_wr, xfer, last_word, wr_last;
  logic [ANCHOPALABRA-1:0] wr_real, wr_imag;

  // A half is available either from its pending register or from an edge
  // arriving this very cycle, so both halves landing together (or the
  // second half landing) writes the pair on the same edge it is seen.
  always_comb begin
    edge_r     = flagR & ~flagR_q;
    edge_i     = flagI & ~flagI_q;
    in_collect = (state_q == S_COLLECT);
    in_drain   = (state_q == S_DRAIN);
    pair_wr    = in_collect & (pend_r_v | edge_r) & (pend_i_v | edge_i);
    wr_real    = edge_r ? accR : pend_r;
    wr_imag    = edge_i ? accI : pend_i;
    wr_last    = (wr_idx == IDX_W'(NUM - 1));
    last_word  = (rd_idx == IDX_W'(NUM - 1));
    xfer       = in_drain & stream.out_ready;
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  // Next state plus the stream outputs. Data outputs are forced to zero
  // outside DRAIN so nothing from the unreset buffer leaks out.
  always_comb begin
    state_d          = state_q;
    stream.out_valid = 1'b0;
    stream.out_real  = '0;
    stream.out_imag  = '0;
    stream.out_row   = '0;
    stream.out_col   = '0;
    stream.out_last  = 1'b0;
    done             = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (pair_wr && wr_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        stream.out_valid = 1'b1;
        stream.out_real  = mem_r[rd_idx];
        stream.out_imag  = mem_i[rd_idx];
        stream.out_row   = row_cnt;
        stream.out_col   = col_cnt;
        stream.out_last  = last_word;
        if (xfer && last_word) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (clr) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Capture, pairing, indices and sticky errors. clr is applied last so a
  // clear wins over an error raised in the same cycle.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      flagR_q  <= 1'b0;
      flagI_q  <= 1'b0;
      pend_r   <= '0;
      pend_i   <= '0;
      pend_r_v <= 1'b0;
      pend_i_v <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      err_pair <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      flagR_q <= flagR;
      flagI_q <= flagI;

      if (in_collect) begin
        if (edge_r) begin
          pend_r <= accR;
          if (pend_r_v) err_pair <= 1'b1;
        end
        if (edge_i) begin
          pend_i <= accI;
          if (pend_i_v) err_pair <= 1'b1;
        end
        if (pair_wr) begin
          pend_r_v <= 1'b0;
          pend_i_v <= 1'b0;
          wr_idx   <= wr_last ? '0 : wr_idx + IDX_W'(1);
        end else begin
          if (edge_r) pend_r_v <= 1'b1;
          if (edge_i) pend_i_v <= 1'b1;
        end
      end else if (edge_r || edge_i) begin
        err_ovf <= 1'b1;
      end

      if (xfer) begin
        if (last_word) begin
          rd_idx  <= '0;
          row_cnt <= '0;
          col_cnt <= '0;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
          if (col_cnt == RC_W'(DIM - 1)) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + RC_W'(1);
          end else begin
            col_cnt <= col_cnt + RC_W'(1);
          end
        end
      end

      if (clr) begin
        err_pair <= 1'b0;
        err_ovf  <= 1'b0;
        if (state_q == S_DONE) begin
          wr_idx   <= '0;
          rd_idx   <= '0;
          row_cnt  <= '0;
          col_cnt  <= '0;
          pend_r_v <= 1'b0;
          pend_i_v <= 1'b0;
        end
      end
    end
  end

  // Matrix storage, intentionally not reset.
  always_ff @(posedge clk_fast) begin
    if (pair_wr) begin
      mem_r[wr_idx] <= wr_real;
      mem_i[wr_idx] <= wr_imag;
    end
  end

`ifdef RESCOL_CHECKSUM_EN
  // Running XOR over both halves of every stored element; restarts with
  // the next matrix.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst)                            checksum <= '0;
    else if (clr && state_q == S_DONE)  checksum <= '0;
    else if (pair_wr)                   checksum <= checksum ^ wr_real ^ wr_imag;
  end
`endif

endmodule
